// File: rtl/res_byte_tx_pkg.sv
// Shared constants for the result-to-UART byte transmitter.
package res_byte_tx_pkg;

    localparam int unsigned BYTE_W = 8;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWaitAck,
        StWaitDone
    } tx_state_e;

endpackage

// File: rtl/res_byte_tx.sv
// Captures one ALU/CMP result word and streams it byte-by-byte to the UART transmitter.
// Results that arrive while a word is in flight are dropped and flagged on OVF.
module res_byte_tx
    import res_byte_tx_pkg::*;
#(
    parameter int unsigned N         = 16,
    parameter bit          MSB_FIRST = 1'b0,
    parameter int unsigned ACK_TO    = 15
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [N-1:0]     RES_DATA,
    input  logic             RES_VALID,
    input  logic             OVF_CLR,
    input  logic             TX_BUSY,
    output logic [BYTE_W-1:0] TX_P_DATA,
    output logic             TX_D_VALID,
    output logic             BUSY,
    output logic             OVF
);

    localparam int unsigned BYTES = N / BYTE_W;
    localparam int unsigned IDXW  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int unsigned TOW   = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;

    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(BYTES - 1);
    localparam logic [TOW-1:0]  TO_LAST  = TOW'(ACK_TO - 1);

    tx_state_e         state;
    logic [N-1:0]      buffer;
    logic [IDXW-1:0]   idx;
    logic [TOW-1:0]    tocnt;
    int unsigned       byte_sel;
    logic [BYTE_W-1:0] cur_byte;
    logic              last_done;

    always_comb begin
        byte_sel = MSB_FIRST ? (BYTES - 1 - 32'(idx)) : 32'(idx);
        cur_byte = BYTE_W'(buffer >> (BYTE_W * byte_sel));
    end

    // Final byte acknowledged this cycle: the only busy cycle where a new result is accepted.
    assign last_done = (state == StWaitDone) && !TX_BUSY && (idx == IDX_LAST);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= StIdle;
            buffer     <= '0;
            idx        <= '0;
            tocnt      <= '0;
            TX_P_DATA  <= '0;
            TX_D_VALID <= 1'b0;
            BUSY       <= 1'b0;
            OVF        <= 1'b0;
        end else begin
            TX_D_VALID <= 1'b0;
            if (OVF_CLR) begin
                OVF <= 1'b0;
            end
            // A drop in the same cycle as OVF_CLR must leave OVF set, so this comes second.
            if (RES_VALID && state != StIdle && !last_done) begin
                OVF <= 1'b1;
            end

            unique case (state)
                StIdle: begin
                    if (RES_VALID) begin
                        buffer <= RES_DATA;
                        idx    <= '0;
                        BUSY   <= 1'b1;
                        state  <= StLoad;
                    end
                end
                StLoad: begin
                    if (!TX_BUSY) begin
                        TX_P_DATA  <= cur_byte;
                        TX_D_VALID <= 1'b1;
                        tocnt      <= '0;
                        state      <= StWaitAck;
                    end
                end
                StWaitAck: begin
                    if (TX_BUSY) begin
                        state <= StWaitDone;
                    end else if (tocnt == TO_LAST) begin
                        state <= StLoad;
                    end else begin
                        tocnt <= tocnt + 1'b1;
                    end
                end
                StWaitDone: begin
                    if (!TX_BUSY) begin
                        if (idx != IDX_LAST) begin
                            idx   <= idx + 1'b1;
                            state <= StLoad;
                        end else if (RES_VALID) begin
                            buffer <= RES_DATA;
                            idx    <= '0;
                            state  <= StLoad;
                        end else begin
                            BUSY  <= 1'b0;
                            state <= StIdle;
                        end
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_res_byte_tx.sv
// Directed bench for res_byte_tx: two instances (LSB-first and MSB-first) share all stimulus.
module tb_res_byte_tx;

    logic        CLK;
    logic        RST;
    logic [15:0] res_data;
    logic        res_valid;
    logic        ovf_clr;
    logic        tx_busy;

    logic [7:0]  txd_l, txd_m;
    logic        txv_l, txv_m;
    logic        busy_l, busy_m;
    logic        ovf_l, ovf_m;

    int n_chk = 0;
    int n_bad = 0;

    res_byte_tx #(.N(16), .MSB_FIRST(1'b0), .ACK_TO(4)) dut_l (
        .CLK        (CLK),
        .RST        (RST),
        .RES_DATA   (res_data),
        .RES_VALID  (res_valid),
        .OVF_CLR    (ovf_clr),
        .TX_BUSY    (tx_busy),
        .TX_P_DATA  (txd_l),
        .TX_D_VALID (txv_l),
        .BUSY       (busy_l),
        .OVF        (ovf_l)
    );

    res_byte_tx #(.N(16), .MSB_FIRST(1'b1), .ACK_TO(4)) dut_m (
        .CLK        (CLK),
        .RST        (RST),
        .RES_DATA   (res_data),
        .RES_VALID  (res_valid),
        .OVF_CLR    (ovf_clr),
        .TX_BUSY    (tx_busy),
        .TX_P_DATA  (txd_m),
        .TX_D_VALID (txv_m),
        .BUSY       (busy_m),
        .OVF        (ovf_m)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic expect_pulse(input string tag, input logic [7:0] el, input logic [7:0] em);
        chk({tag, " valid_l"}, 16'(txv_l), 16'd1);
        chk({tag, " valid_m"}, 16'(txv_m), 16'd1);
        chk({tag, " data_l"}, 16'(txd_l), 16'(el));
        chk({tag, " data_m"}, 16'(txd_m), 16'(em));
    endtask

    task automatic expect_idle_outs(input string tag);
        chk({tag, " data_l"}, 16'(txd_l), 16'd0);
        chk({tag, " data_m"}, 16'(txd_m), 16'd0);
        chk({tag, " valid"}, 16'({txv_l, txv_m}), 16'd0);
        chk({tag, " busy"}, 16'({busy_l, busy_m}), 16'd0);
        chk({tag, " ovf"}, 16'({ovf_l, ovf_m}), 16'd0);
    endtask

    // UART frame: busy rises the cycle after the pulse, holds 2 cycles, then drops.
    task automatic ack_byte(input string tag);
        tx_busy = 1'b1;
        tick();
        chk({tag, " one-pulse"}, 16'({txv_l, txv_m}), 16'd0);
        tick();
        tx_busy = 1'b0;
        tick();
    endtask

    initial begin
        RST = 1'b0;
        res_data = '0;
        res_valid = 1'b0;
        ovf_clr = 1'b0;
        tx_busy = 1'b0;
        #3;
        expect_idle_outs("reset");
        tick();
        tick();
        RST = 1'b1;

        // 1: A55A, LSB first gives 5A, A5
        res_data = 16'hA55A;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        chk("t1 busy after accept", 16'({busy_l, busy_m}), 16'b11);
        chk("t1 no pulse at e0", 16'({txv_l, txv_m}), 16'd0);
        tick();
        expect_pulse("t1 byte0", 8'h5A, 8'hA5);
        ack_byte("t1 byte0");
        chk("t1 busy mid", 16'(busy_l), 16'd1);
        tick();
        expect_pulse("t1 byte1", 8'hA5, 8'h5A);
        ack_byte("t1 byte1");
        chk("t1 busy fall", 16'({busy_l, busy_m}), 16'd0);

        // 2: 1234 with TX busy held through three LOAD cycles
        tx_busy = 1'b1;
        res_data = 16'h1234;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2 held off", 16'({txv_l, txv_m}), 16'd0);
        end
        tx_busy = 1'b0;
        tick();
        expect_pulse("t2 byte0", 8'h34, 8'h12);
        ack_byte("t2 byte0");
        tick();
        expect_pulse("t2 byte1", 8'h12, 8'h34);
        ack_byte("t2 byte1");
        chk("t2 done", 16'({busy_l, busy_m}), 16'd0);

        // 3: no ack, same byte re-pulsed every 5 cycles
        res_data = 16'hBEEF;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        tick();
        expect_pulse("t3 first", 8'hEF, 8'hBE);
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                tick();
                chk("t3 gap", 16'({txv_l, txv_m}), 16'd0);
            end
            tick();
            expect_pulse("t3 resend", 8'hEF, 8'hBE);
        end
        chk("t3 ovf", 16'({ovf_l, ovf_m}), 16'd0);
        ack_byte("t3 byte0");
        tick();
        expect_pulse("t3 byte1", 8'hBE, 8'hEF);
        ack_byte("t3 byte1");

        // 4: drop during WAIT_ACK, then clear/drop collision
        res_data = 16'hC3D2;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        tick();
        expect_pulse("t4 byte0", 8'hD2, 8'hC3);
        res_data = 16'hFFFF;
        res_valid = 1'b1;
        tx_busy = 1'b1;
        tick();
        res_valid = 1'b0;
        chk("t4 ovf set", 16'({ovf_l, ovf_m}), 16'b11);
        tick();
        tx_busy = 1'b0;
        tick();
        res_valid = 1'b1;
        ovf_clr = 1'b1;
        tick();
        res_valid = 1'b0;
        ovf_clr = 1'b0;
        chk("t4 drop beats clr", 16'({ovf_l, ovf_m}), 16'b11);
        expect_pulse("t4 byte1 intact", 8'hC3, 8'hD2);
        ack_byte("t4 byte1");
        chk("t4 idle", 16'({busy_l, busy_m}), 16'd0);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t4 ovf clr", 16'({ovf_l, ovf_m}), 16'd0);

        // 5: back-to-back accept on completion, then reset mid-word
        res_data = 16'h0102;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        tick();
        expect_pulse("t5 w0 byte0", 8'h02, 8'h01);
        ack_byte("t5 w0 byte0");
        tick();
        expect_pulse("t5 w0 byte1", 8'h01, 8'h02);
        tx_busy = 1'b1;
        tick();
        tick();
        tx_busy = 1'b0;
        res_data = 16'h7788;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        chk("t5 busy kept", 16'({busy_l, busy_m}), 16'b11);
        chk("t5 no drop", 16'({ovf_l, ovf_m}), 16'd0);
        tick();
        expect_pulse("t5 w1 byte0", 8'h88, 8'h77);
        ack_byte("t5 w1 byte0");
        tick();
        expect_pulse("t5 w1 byte1", 8'h77, 8'h88);
        res_data = 16'h0000;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        chk("t5 ovf pre-reset", 16'({ovf_l, ovf_m}), 16'b11);
        RST = 1'b0;
        #1;
        expect_idle_outs("t5 async reset");
        tick();
        tick();
        RST = 1'b1;
        res_data = 16'h5566;
        res_valid = 1'b1;
        tick();
        res_valid = 1'b0;
        tick();
        expect_pulse("t5 restart byte0", 8'h66, 8'h55);
        ack_byte("t5 restart byte0");
        tick();
        expect_pulse("t5 restart byte1", 8'h55, 8'h66);
        ack_byte("t5 restart byte1");
        chk("t5 end idle", 16'({busy_l, busy_m}), 16'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
